// File: rtl/mem_port_arbiter_if.sv
// Bundle between the arbiter, the fetch port, the load/store port and the SRAM.
// slave  : arbiter side (takes requests, drives the SRAM, returns read data)
// master : environment side (requesters plus SRAM read data)
// Ports: fetch (if_*), data (d_*) and SRAM (mem_*) signal groups.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 10
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = 4;

    logic              if_req;
    logic [WORD_W-1:0] if_addr;
    logic              if_ready;
    logic              if_rvalid;
    logic [WORD_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [WORD_W-1:0] d_addr;
    logic [WORD_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_be;
    logic              d_ready;
    logic              d_rvalid;
    logic [WORD_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_ready, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_ready, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_ready, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_ready, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and load/store.
// Data has priority; a starvation counter forces a fetch grant after
// STARVE_MAX consecutive data grants while fetch waits.
// Ports: clk, reset (synchronous, active-high), bus (slave modport:
// fetch request/response, data request/response, SRAM strobe/address/data).
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CNT_W  = 4;

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    // Read-response owner encoding
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;

    logic              gnt_if;
    logic              gnt_d;
    logic [ADDR_W-1:0] if_waddr;
    logic [ADDR_W-1:0] d_waddr;

    logic [1:0]        rd_owner_q, rd_owner_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic [WORD_W-1:0] if_hold_q, if_hold_d;
    logic [WORD_W-1:0] d_hold_q, d_hold_d;

    // Byte addresses reduced to word addresses; remaining bits are don't-care
    assign if_waddr = bus.if_addr[ADDR_W+1:2];
    assign d_waddr  = bus.d_addr[ADDR_W+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr[WORD_W-1:ADDR_W+2], bus.if_addr[1:0],
                                bus.d_addr[WORD_W-1:ADDR_W+2], bus.d_addr[1:0]};

    // Grant: data wins unless fetch has waited STARVE_MAX data grants
    always_comb begin
        gnt_if = 1'b0;
        gnt_d  = 1'b0;
        if (!reset) begin
            if (bus.d_req && !(bus.if_req && (starve_q == STARVE_LIM))) begin
                gnt_d = 1'b1;
            end else if (bus.if_req) begin
                gnt_if = 1'b1;
            end
        end
    end

    assign bus.if_ready = gnt_if;
    assign bus.d_ready  = gnt_d;

    // SRAM drive from the winner, all zero when idle
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (gnt_if) begin
            bus.mem_en   = 1'b1;
            bus.mem_be   = {BE_W{1'b1}};
            bus.mem_addr = if_waddr;
        end else if (gnt_d) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.d_we;
            bus.mem_be    = bus.d_we ? bus.d_be : {BE_W{1'b1}};
            bus.mem_addr  = d_waddr;
            bus.mem_wdata = bus.d_wdata;
        end
    end

    // Response routing; reset squashes an in-flight response
    assign bus.if_rvalid = !reset && (rd_owner_q == OWN_IF);
    assign bus.d_rvalid  = !reset && (rd_owner_q == OWN_D);
    assign bus.if_rdata  = reset ? '0 : (bus.if_rvalid ? bus.mem_rdata : if_hold_q);
    assign bus.d_rdata   = reset ? '0 : (bus.d_rvalid  ? bus.mem_rdata : d_hold_q);

    // Next state: response owner, hold registers, starvation counter
    always_comb begin
        rd_owner_d = OWN_NONE;
        if_hold_d  = if_hold_q;
        d_hold_d   = d_hold_q;
        starve_d   = starve_q;

        if (gnt_if) begin
            rd_owner_d = OWN_IF;
        end else if (gnt_d && !bus.d_we) begin
            rd_owner_d = OWN_D;
        end

        if (bus.if_rvalid) if_hold_d = bus.mem_rdata;
        if (bus.d_rvalid)  d_hold_d  = bus.mem_rdata;

        if (gnt_if || !bus.if_req) begin
            starve_d = '0;
        end else if (gnt_d && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_owner_q <= OWN_NONE;
            starve_q   <= '0;
            if_hold_q  <= '0;
            d_hold_q   <= '0;
        end else begin
            rd_owner_q <= rd_owner_d;
            starve_q   <= starve_d;
            if_hold_q  <= if_hold_d;
            d_hold_q   <= d_hold_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner
// sequences and random traffic, all checked against a behavioural model.
module tb_mem_port_arbiter;
    localparam int unsigned AW     = 10;
    localparam int          STARVE = 4;
    localparam int          DEPTH  = 1024;

    logic clk = 1'b0;
    logic rst;
    logic load_mem;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .STARVE_MAX(STARVE)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 5) return 32'h0000_0013;
        return 32'(i) * 32'h9E37_79B1 + 32'h1;
    endfunction

    // SRAM: byte-enable writes, read data one cycle after the strobe
    logic [31:0] sram [DEPTH];
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < DEPTH; i++) sram[i] <= init_word(i);
        end else if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) sram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end else begin
                bus.mem_rdata <= sram[bus.mem_addr];
            end
        end
    end

    // Reference model state
    logic [31:0] ref_mem [DEPTH];
    int          waited;      // data grants in a row while fetch was pending
    int          pend_own;    // 0 none, 1 fetch, 2 data
    logic [31:0] pend_data;
    logic [31:0] hold_if, hold_d;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  s_ctl;       // {if_ready, d_ready, mem_en, mem_we, mem_be}
    logic [9:0]  s_addr;
    logic [31:0] s_wdata;
    logic [1:0]  s_rv;        // {if_rvalid, d_rvalid}
    logic [31:0] s_if_rdata, s_d_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dbe);
        bus.if_req  = ir;
        bus.if_addr = ia;
        bus.d_req   = dr;
        bus.d_we    = dw;
        bus.d_addr  = da;
        bus.d_wdata = dwd;
        bus.d_be    = dbe;
    endtask

    function automatic logic [9:0] word_of(input logic [31:0] a);
        return 10'((a / 4) % DEPTH);
    endfunction

    // One clock: predict, sample at negedge and compare, advance model at posedge
    task automatic cycle();
        int          g;
        logic [9:0]  fa, da;
        logic        e_we;
        logic [7:0]  e_ctl;
        logic [9:0]  e_addr;
        logic [31:0] e_wdata, e_ifd, e_dd;
        logic [1:0]  e_rv;
        fa = word_of(bus.if_addr);
        da = word_of(bus.d_addr);
        g  = 0;
        if (!rst) begin
            if (bus.d_req && bus.if_req) g = (waited >= STARVE) ? 1 : 2;
            else if (bus.d_req)          g = 2;
            else if (bus.if_req)         g = 1;
        end
        e_we    = (g == 2) && bus.d_we;
        e_ctl   = {g == 1, g == 2, g != 0, e_we,
                   (g == 0) ? 4'h0 : (e_we ? bus.d_be : 4'hF)};
        e_addr  = (g == 1) ? fa : ((g == 2) ? da : 10'd0);
        e_wdata = (g == 2) ? bus.d_wdata : 32'd0;
        e_rv    = {!rst && pend_own == 1, !rst && pend_own == 2};
        e_ifd   = rst ? 32'd0 : (e_rv[1] ? pend_data : hold_if);
        e_dd    = rst ? 32'd0 : (e_rv[0] ? pend_data : hold_d);

        @(negedge clk);
        s_ctl      = {bus.if_ready, bus.d_ready, bus.mem_en, bus.mem_we, bus.mem_be};
        s_addr     = bus.mem_addr;
        s_wdata    = bus.mem_wdata;
        s_rv       = {bus.if_rvalid, bus.d_rvalid};
        s_if_rdata = bus.if_rdata;
        s_d_rdata  = bus.d_rdata;
        check("model grant/ctl", 32'(s_ctl), 32'(e_ctl));
        check("model mem_addr", 32'(s_addr), 32'(e_addr));
        check("model mem_wdata", s_wdata, e_wdata);
        check("model rvalid", 32'(s_rv), 32'(e_rv));
        check("model if_rdata", s_if_rdata, e_ifd);
        check("model d_rdata", s_d_rdata, e_dd);

        @(posedge clk);
        if (rst) begin
            waited   = 0;
            pend_own = 0;
            hold_if  = '0;
            hold_d   = '0;
        end else begin
            if (pend_own == 1) hold_if = pend_data;
            if (pend_own == 2) hold_d  = pend_data;
            pend_own = 0;
            if (g == 1) begin
                pend_own  = 1;
                pend_data = ref_mem[fa];
            end else if (g == 2) begin
                if (bus.d_we) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.d_be[b]) ref_mem[da][8*b +: 8] = bus.d_wdata[8*b +: 8];
                end else begin
                    pend_own  = 2;
                    pend_data = ref_mem[da];
                end
            end
            if (!bus.if_req || g == 1) waited = 0;
            else if (waited < STARVE) waited++;
        end
        #1;
    endtask

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [3:0]  dbe;
        logic [7:0]  e_ctl;
        logic [9:0]  e_addr;
        logic [31:0] e_wdata;
        logic [1:0]  e_rv;
    } vec_t;

    vec_t        vecs [8];
    string       pat;
    logic [1:0]  prev_g;
    logic [31:0] w8;

    initial begin
        vecs[0] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   32'h0,         4'h0, 8'h00, 10'h000, 32'h0,         2'b00};
        vecs[1] = '{1'b1, 32'h10,        1'b0, 1'b0, 32'h0,   32'h0,         4'h0, 8'hAF, 10'h004, 32'h0,         2'b00};
        vecs[2] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h20,  32'hAABBCCDD,  4'h3, 8'h73, 10'h008, 32'hAABBCCDD,  2'b10};
        vecs[3] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h20,  32'h0,         4'h0, 8'h6F, 10'h008, 32'h0,         2'b00};
        vecs[4] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   32'h0,         4'h0, 8'h00, 10'h000, 32'h0,         2'b01};
        vecs[5] = '{1'b1, 32'hFFFFF013,  1'b0, 1'b0, 32'h0,   32'h0,         4'h0, 8'hAF, 10'h004, 32'h0,         2'b00};
        vecs[6] = '{1'b1, 32'h40,        1'b1, 1'b0, 32'hFFC, 32'h12345678,  4'h0, 8'h6F, 10'h3FF, 32'h12345678,  2'b10};
        vecs[7] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   32'h0,         4'h0, 8'h00, 10'h000, 32'h0,         2'b01};

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        waited = 0; pend_own = 0; pend_data = '0; hold_if = '0; hold_d = '0;
        rst = 1'b1;
        load_mem = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;

        // Reset state, including requests presented while in reset
        cycle();
        load_mem = 1'b0;
        drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        cycle();
        check("reset no grant", 32'(s_ctl), 32'h0);
        check("reset rdata", s_if_rdata | s_d_rdata, 32'h0);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].dwd, vecs[i].dbe);
            cycle();
            check($sformatf("vec%0d ctl", i), 32'(s_ctl), 32'(vecs[i].e_ctl));
            check($sformatf("vec%0d mem_addr", i), 32'(s_addr), 32'(vecs[i].e_addr));
            check($sformatf("vec%0d mem_wdata", i), s_wdata, vecs[i].e_wdata);
            check($sformatf("vec%0d rvalid", i), 32'(s_rv), 32'(vecs[i].e_rv));
            if (i == 2) check("fetch data word4", s_if_rdata, init_word(4));
            if (i == 4) begin
                w8 = init_word(8);
                check("store/load merge", s_d_rdata, {w8[31:16], 16'hCCDD});
            end
        end

        // Contention: grant pattern repeats every STARVE_MAX+1 cycles
        pat = "DDDDIDDDDI";
        prev_g = 2'b00;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'h40, 1'b1, 1'b0, 32'(32'h100 + k * 4), 32'h0, 4'h0);
            cycle();
            check($sformatf("contention grant %0d", k), 32'(s_ctl[7:6]),
                  (pat[k] == "I") ? 32'h2 : 32'h1);
            if (k > 0) check($sformatf("contention rvalid %0d", k), 32'(s_rv), 32'(prev_g));
            prev_g = s_ctl[7:6];
        end

        // Fetch hold register keeps the last delivered word
        drive(1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cycle();
        check("fetch 0x13", s_if_rdata, 32'h13);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check($sformatf("if hold %0d", k), {31'd0, s_rv[1]} | s_if_rdata ^ 32'h13, 32'h0);
        end

        // Reset mid-read after a starvation build-up
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h40, 1'b1, 1'b0, 32'(32'h200 + k * 4), 32'h0, 4'h0);
            cycle();
        end
        rst = 1'b1;
        cycle();
        check("reset squash rvalid", 32'(s_rv), 32'h0);
        check("reset d_rdata", s_d_rdata, 32'h0);
        check("reset mem_en", 32'(s_ctl[5]), 32'h0);
        rst = 1'b0;
        pat = "DDDDI";
        for (int k = 0; k < 5; k++) begin
            cycle();
            check($sformatf("post-reset grant %0d", k), 32'(s_ctl[7:6]),
                  (pat[k] == "I") ? 32'h2 : 32'h1);
        end

        // Idle
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cycle();
        cycle();
        check("idle ctl", 32'(s_ctl), 32'h0);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 49) == 0);
            drive(1'($urandom), ($urandom & 32'hFFFF_F003) | 32'($urandom_range(0, 15) * 4),
                  1'($urandom), 1'($urandom),
                  ($urandom & 32'hFFFF_F003) | 32'($urandom_range(0, 15) * 4),
                  $urandom, 4'($urandom));
            cycle();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one single-port, word-wide synchronous memory between the core's instruction-fetch port and its load/store data port. Sits between the fetch/PC stage, the load/store unit and a unified code+data SRAM. Each cycle it grants at most one requester, drives the SRAM and routes the one-cycle-late read data back to the owner. Data has priority, and a starvation counter guarantees fetch progress.

## Interface
- ADDR_W, 10, SRAM word-address width (1024 words)
- STARVE_MAX, 4, max consecutive data grants while fetch waits (1..15)

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request
- if_addr  in  32  fetch byte address
- if_ready  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  32  fetch read data
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, lane-aligned
- d_be  in  4  store byte enables
- d_ready  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  32  load data
- mem_en  out  1  SRAM access strobe
- mem_we  out  1  SRAM write
- mem_be  out  4  SRAM byte enables
- mem_addr  out  ADDR_W  SRAM word address
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data, valid the cycle after a read strobe

## Operation
- Word address = byte address[ADDR_W+1:2]. Address bits [1:0] and bits above ADDR_W+1 are ignored.
- Grant decision is combinational, at most one grant per cycle:
  - Only one requester: it wins.
  - Both requesting: data wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
  - reset high: no grant.
- A granted request asserts its ready in the same cycle. mem_en = 1 and mem_* are driven from the winner.
  - Fetch: mem_we = 0, mem_be = 4'hF.
  - Data: mem_we = d_we, mem_be = d_we ? d_be : 4'hF.
- With no grant: mem_en = 0, mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0.
- Store: completes in the grant cycle. No rvalid is produced.
- Read response pipeline: a registered rd_owner ∈ {NONE, IF, D} is loaded each cycle with the owner of a read grant, or NONE if there is no read grant. The next cycle asserts that owner's rvalid.
- rdata: equals mem_rdata in the rvalid cycle. Otherwise it holds the last delivered value from a per-port hold register.
- starve_cnt, 4 bits:
  - Increments when data is granted while if_req = 1.
  - Clears when fetch is granted or if_req = 0.
  - Saturates at STARVE_MAX.
- Back-to-back grants are allowed every cycle. Responses are in order, one per read.
- Requesters must hold req/addr/wdata/be stable until ready. The arbiter does not latch unaccepted requests.

## Timing
- Reset values: rd_owner = NONE, starve_cnt = 0, both rdata hold registers = 0. if_rvalid = d_rvalid = 0. if_rdata = d_rdata = 0.
- During reset: if_ready = d_ready = 0, mem_en = 0.
- Reset mid-operation: a read granted in cycle N followed by reset in cycle N+1 produces no rvalid in N+1. The in-flight response is squashed.
- Latency:
  - Read: grant in cycle N, rvalid in N+1.
  - Write: committed at the clk edge ending cycle N.
- Simultaneous events: a grant in cycle N and an rvalid for the cycle N−1 grant coexist, possibly on different ports.
- Read-after-write to the same word from consecutive grants returns the new data. This relies on the SRAM write-then-read ordering.
- With both requesting continuously, the grant pattern repeats with period STARVE_MAX+1: STARVE_MAX data grants, then 1 fetch grant.

## Test plan
- Fetch only: if_req = 1, if_addr = 0x0000_0010 → if_ready = 1 and mem_addr = 4 in cycle N. In N+1, if_rvalid = 1 and if_rdata = mem[4]. d_rvalid stays 0.
- Store then load: d_we = 1, d_addr = 0x20, d_wdata = 0xAABBCCDD, d_be = 4'b0011 → mem_we = 1, mem_be = 0011, mem_addr = 8. Next cycle a load of 0x20 returns 0x????CCDD, with the upper half preserved from the prior contents, and d_rvalid = 1.
- Contention, STARVE_MAX = 4: if_req and d_req held high with loads for 10 cycles → grants D,D,D,D,IF,D,D,D,D,IF. Each rvalid pulse is on the port granted in the prior cycle.
- Rdata hold: after a fetch returns 0x00000013, hold if_req = 0 for 3 cycles → if_rdata stays 0x00000013 and if_rvalid = 0.
- Reset mid-read: load granted in cycle N, reset = 1 in N+1 → d_rvalid = 0, d_rdata = 0, mem_en = 0, starve_cnt = 0. After release, the first request is granted normally.
- Idle: both req = 0 → mem_en = 0, all mem_* = 0, both ready = 0, starve_cnt = 0.
